// File: rtl/dma_fifo_device_if.sv
// Peripheral-bus and DMA device-port signals of dma_fifo_device.
// The master side is the CPU bus plus DMA controller; the slave side is the device.
interface dma_fifo_device_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        irq;
  logic        dma_rqst;
  logic        dma_rd_wr;
  logic [15:0] dma_start_address;
  logic [15:0] dma_num_words;
  logic        dev_ack;
  logic [15:0] dev_out;
  logic        dma_ack;
  logic [15:0] dev_in;
  logic        dma_end_flag;
  logic        dma_error_flag;

  modport master (
    output per_addr, per_din, per_en, per_we, dma_ack, dev_in, dma_end_flag, dma_error_flag,
    input  per_dout, irq, dma_rqst, dma_rd_wr, dma_start_address, dma_num_words, dev_ack, dev_out
  );

  modport slave (
    input  per_addr, per_din, per_en, per_we, dma_ack, dev_in, dma_end_flag, dma_error_flag,
    output per_dout, irq, dma_rqst, dma_rd_wr, dma_start_address, dma_num_words, dev_ack, dev_out
  );
endinterface

// File: rtl/dma_fifo_device.sv
// DMA-programming peripheral with RX/TX word FIFOs, sticky status and interrupt.
// state | meaning
// IDLE  | no transfer; configuration writable
// RUN   | transfer in progress; dma_rqst high, config frozen
module dma_fifo_device #(
  parameter logic [14:0] BASE_ADDR = 15'h0100,
  parameter int          DEC_WD    = 4,
  parameter int          FIFO_AW   = 3
) (
  input logic           clk,
  input logic           reset,
  dma_fifo_device_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = FIFO_AW + 1;
  localparam int OW    = DEC_WD - 1;

  localparam logic [OW-1:0] R_START  = OW'(0);
  localparam logic [OW-1:0] R_NWORDS = OW'(1);
  localparam logic [OW-1:0] R_CTRL   = OW'(2);
  localparam logic [OW-1:0] R_STATUS = OW'(3);
  localparam logic [OW-1:0] R_RDDATA = OW'(4);
  localparam logic [OW-1:0] R_WRDATA = OW'(5);
  localparam logic [OW-1:0] R_LEVEL  = OW'(6);
  localparam logic [OW-1:0] R_COUNT  = OW'(7);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_n;
  logic [15:0] start_addr, n_words, count, count_n;
  logic        dir, irq_en, irq_en_n;
  logic        done, done_n, error, error_n;
  logic        tx_ovf, tx_ovf_n, rx_unf, rx_unf_n;
  logic        irq_q;

  logic [15:0]        rx_mem [DEPTH];
  logic [15:0]        tx_mem [DEPTH];
  logic [FIFO_AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [LW-1:0]      rx_lvl, tx_lvl;

  logic          reg_sel, wr, rd;
  logic [OW-1:0] reg_off;
  logic          wr_start, wr_nwords, wr_ctrl, wr_status, wr_wdata, rd_rdata;
  logic          start_pulse, flush, abort;
  logic          busy, beat, dev_ack_c;
  logic          rx_empty, rx_full, tx_empty, tx_full;
  logic          rx_push, rx_pop, tx_push, tx_pop;
  logic [15:0]   status, dout;

  assign reg_sel = bus.per_en && (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_off = bus.per_addr[OW-1:0];
  assign wr      = reg_sel && (bus.per_we != 2'b00);
  assign rd      = reg_sel && (bus.per_we == 2'b00);

  assign wr_start  = wr && (reg_off == R_START);
  assign wr_nwords = wr && (reg_off == R_NWORDS);
  assign wr_ctrl   = wr && (reg_off == R_CTRL);
  assign wr_status = wr && (reg_off == R_STATUS);
  assign wr_wdata  = wr && (reg_off == R_WRDATA);
  assign rd_rdata  = rd && (reg_off == R_RDDATA);

  assign start_pulse = wr_ctrl && bus.per_din[0];
  assign flush       = wr_ctrl && bus.per_din[3];
  assign abort       = wr_ctrl && bus.per_din[4];
  assign irq_en_n    = wr_ctrl ? bus.per_din[2] : irq_en;

  assign busy     = (state == RUN);
  assign rx_empty = (rx_lvl == '0);
  assign rx_full  = (rx_lvl == LW'(DEPTH));
  assign tx_empty = (tx_lvl == '0);
  assign tx_full  = (tx_lvl == LW'(DEPTH));

  assign dev_ack_c = busy && (dir ? !rx_full : !tx_empty);
  assign beat      = busy && bus.dma_ack && dev_ack_c;

  assign rx_push = beat && dir;
  assign rx_pop  = rd_rdata && !rx_empty;
  assign tx_pop  = beat && !dir;
  // A pop in the same cycle frees the slot, so a full TX can still accept the push.
  assign tx_push = wr_wdata && (!tx_full || tx_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_addr <= '0;
      n_words    <= '0;
      dir        <= 1'b0;
      irq_en     <= 1'b0;
    end else begin
      if (wr_start && !busy)  start_addr <= bus.per_din;
      if (wr_nwords && !busy) n_words    <= bus.per_din;
      if (wr_ctrl) begin
        irq_en <= bus.per_din[2];
        if (!busy) dir <= bus.per_din[1];
      end
    end
  end

  always_comb begin
    state_n  = state;
    done_n   = done;
    error_n  = error;
    tx_ovf_n = tx_ovf;
    rx_unf_n = rx_unf;
    count_n  = count;
    if (wr_status) begin
      if (bus.per_din[1]) done_n   = 1'b0;
      if (bus.per_din[2]) error_n  = 1'b0;
      if (bus.per_din[7]) tx_ovf_n = 1'b0;
      if (bus.per_din[8]) rx_unf_n = 1'b0;
    end
    if (wr_wdata && tx_full && !tx_pop) tx_ovf_n = 1'b1;
    if (rd_rdata && rx_empty)           rx_unf_n = 1'b1;
    if (beat && (count != 16'hFFFF))    count_n  = count + 16'd1;
    case (state)
      IDLE: begin
        if (start_pulse) begin
          if (n_words != 16'd0) begin
            state_n = RUN;
            count_n = '0;
            done_n  = 1'b0;
            error_n = 1'b0;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.dma_error_flag) begin
          state_n = IDLE;
          error_n = 1'b1;
        end else if (bus.dma_end_flag) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (abort) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      error  <= 1'b0;
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
      count  <= '0;
      irq_q  <= 1'b0;
    end else begin
      state  <= state_n;
      done   <= done_n;
      error  <= error_n;
      tx_ovf <= tx_ovf_n;
      rx_unf <= rx_unf_n;
      count  <= count_n;
      irq_q  <= irq_en_n && (done_n || error_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push && !flush) rx_mem[rx_wp] <= bus.dev_in;
    if (tx_push && !flush) tx_mem[tx_wp] <= bus.per_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_lvl <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_lvl <= '0;
    end else if (flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_lvl <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_lvl <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      rx_lvl <= rx_lvl + LW'(rx_push) - LW'(rx_pop);
      tx_lvl <= tx_lvl + LW'(tx_push) - LW'(tx_pop);
    end
  end

  assign status = {7'b0, rx_unf, tx_ovf, tx_full, tx_empty, rx_full, rx_empty, error, done, busy};

  always_comb begin
    dout = '0;
    if (rd) begin
      case (reg_off)
        R_START:  dout = start_addr;
        R_NWORDS: dout = n_words;
        R_CTRL:   dout = {11'b0, 2'b00, irq_en, dir, 1'b0};
        R_STATUS: dout = status;
        R_RDDATA: dout = rx_empty ? 16'h0000 : rx_mem[rx_rp];
        R_LEVEL:  dout = {8'(tx_lvl), 8'(rx_lvl)};
        R_COUNT:  dout = count;
        default:  dout = '0;
      endcase
    end
  end

  assign bus.per_dout          = dout;
  assign bus.irq               = irq_q;
  assign bus.dma_rqst          = busy;
  assign bus.dma_rd_wr         = dir;
  assign bus.dma_start_address = start_addr;
  assign bus.dma_num_words     = n_words;
  assign bus.dev_ack           = dev_ack_c;
  assign bus.dev_out           = tx_empty ? 16'h0000 : tx_mem[tx_rp];

endmodule

// File: tb/tb_dma_fifo_device.sv
// Directed bench for dma_fifo_device: transfers, backpressure, flags, FIFO edges, reset.
module tb_dma_fifo_device;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  dma_fifo_device_if bus_if ();

  dma_fifo_device #(.BASE_ADDR(15'h0100), .DEC_WD(4), .FIFO_AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [3:0] off, input logic [15:0] data);
    bus_if.per_addr = {11'h010, off[3:1]};
    bus_if.per_din  = data;
    bus_if.per_we   = 2'b11;
    bus_if.per_en   = 1'b1;
    cyc();
    bus_if.per_en   = 1'b0;
    bus_if.per_we   = 2'b00;
  endtask

  task automatic cpu_rd(input logic [3:0] off, output logic [15:0] data);
    bus_if.per_addr = {11'h010, off[3:1]};
    bus_if.per_we   = 2'b00;
    bus_if.per_en   = 1'b1;
    #1;
    data = bus_if.per_dout;
    cyc();
    bus_if.per_en   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] off, input logic [15:0] exp);
    logic [15:0] d;
    cpu_rd(off, d);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [15:0] d;
    int beats;
    int first_low;
    n_pass  = 0;
    n_total = 0;
    reset = 1'b1;
    bus_if.per_addr = '0;
    bus_if.per_din  = '0;
    bus_if.per_en   = 1'b0;
    bus_if.per_we   = 2'b00;
    bus_if.dma_ack  = 1'b0;
    bus_if.dev_in   = '0;
    bus_if.dma_end_flag   = 1'b0;
    bus_if.dma_error_flag = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // reset state
    chk("rst_rqst", 16'(bus_if.dma_rqst), 16'h0);
    chk("rst_ack", 16'(bus_if.dev_ack), 16'h0);
    chk("rst_irq", 16'(bus_if.irq), 16'h0);
    chk("rst_dev_out", bus_if.dev_out, 16'h0);
    rd_chk("rst_status", 4'h6, 16'h0028);
    rd_chk("rst_level", 4'hC, 16'h0000);

    // read transfer
    cpu_wr(4'h0, 16'h0200);
    cpu_wr(4'h2, 16'h0003);
    cpu_wr(4'h4, 16'h0003);
    chk("rd_rqst", 16'(bus_if.dma_rqst), 16'h1);
    chk("rd_dir", 16'(bus_if.dma_rd_wr), 16'h1);
    chk("rd_addr", bus_if.dma_start_address, 16'h0200);
    chk("rd_nw", bus_if.dma_num_words, 16'h0003);
    bus_if.dma_ack = 1'b1;
    bus_if.dev_in = 16'h00A1; cyc();
    bus_if.dev_in = 16'h00A2; cyc();
    bus_if.dev_in = 16'h00A3; cyc();
    bus_if.dma_ack = 1'b0;
    bus_if.dma_end_flag = 1'b1; cyc();
    bus_if.dma_end_flag = 1'b0;
    chk("rd_rqst_end", 16'(bus_if.dma_rqst), 16'h0);
    rd_chk("rd_status", 4'h6, 16'h0022);
    rd_chk("rd_level", 4'hC, 16'h0003);
    rd_chk("rd_count", 4'hE, 16'h0003);
    rd_chk("rd_pop1", 4'h8, 16'h00A1);
    rd_chk("rd_pop2", 4'h8, 16'h00A2);
    rd_chk("rd_pop3", 4'h8, 16'h00A3);
    rd_chk("rd_pop_empty", 4'h8, 16'h0000);
    rd_chk("rd_unf_status", 4'h6, 16'h012A);
    cpu_wr(4'h6, 16'h0186);
    rd_chk("rd_clr_status", 4'h6, 16'h0028);

    // backpressure with dma_ack held high
    cpu_wr(4'h2, 16'h000A);
    cpu_wr(4'h4, 16'h0003);
    bus_if.dma_ack = 1'b1;
    beats = 0;
    first_low = -1;
    for (int i = 0; i < 12; i++) begin
      bus_if.dev_in = 16'h0B00 + 16'(i);
      if (bus_if.dev_ack) beats++;
      else if (first_low < 0) first_low = i;
      cyc();
    end
    chk("bp_beats", 16'(beats), 16'd8);
    chk("bp_first_low", 16'(first_low), 16'd8);
    rd_chk("bp_status", 4'h6, 16'h0031);
    rd_chk("bp_pop", 4'h8, 16'h0B00);
    chk("bp_ack_reopen", 16'(bus_if.dev_ack), 16'h1);
    cyc();
    chk("bp_ack_closed", 16'(bus_if.dev_ack), 16'h0);
    rd_chk("bp_level", 4'hC, 16'h0008);
    rd_chk("bp_count", 4'hE, 16'd9);
    bus_if.dma_ack = 1'b0;

    // abort, then flush
    cpu_wr(4'h4, 16'h0010);
    chk("ab_rqst", 16'(bus_if.dma_rqst), 16'h0);
    rd_chk("ab_status", 4'h6, 16'h0030);
    cpu_wr(4'h4, 16'h0008);
    rd_chk("fl_level", 4'hC, 16'h0000);

    // write transfer
    cpu_wr(4'hA, 16'h1111);
    cpu_wr(4'hA, 16'h2222);
    chk("wr_dev_out_idle", bus_if.dev_out, 16'h1111);
    rd_chk("wr_level", 4'hC, 16'h0200);
    cpu_wr(4'h2, 16'h0002);
    cpu_wr(4'h4, 16'h0001);
    chk("wr_dir", 16'(bus_if.dma_rd_wr), 16'h0);
    chk("wr_ack", 16'(bus_if.dev_ack), 16'h1);
    bus_if.dma_ack = 1'b1;
    cyc();
    chk("wr_dev_out2", bus_if.dev_out, 16'h2222);
    cyc();
    bus_if.dma_ack = 1'b0;
    chk("wr_ack_empty", 16'(bus_if.dev_ack), 16'h0);
    chk("wr_dev_out0", bus_if.dev_out, 16'h0000);
    rd_chk("wr_status", 4'h6, 16'h0029);
    bus_if.dma_end_flag = 1'b1; cyc();
    bus_if.dma_end_flag = 1'b0;
    for (int i = 0; i < 8; i++) cpu_wr(4'hA, 16'h3000 + 16'(i));
    rd_chk("wr_full_status", 4'h6, 16'h004A);
    cpu_wr(4'hA, 16'h3008);
    rd_chk("wr_ovf_status", 4'h6, 16'h00CA);
    rd_chk("wr_ovf_level", 4'hC, 16'h0800);
    chk("wr_head_kept", bus_if.dev_out, 16'h3000);
    cpu_wr(4'h4, 16'h0008);
    cpu_wr(4'h6, 16'h0186);
    rd_chk("wr_clr_status", 4'h6, 16'h0028);

    // error with interrupt
    cpu_wr(4'h2, 16'h0005);
    cpu_wr(4'h4, 16'h0007);
    chk("er_irq_pre", 16'(bus_if.irq), 16'h0);
    bus_if.dma_error_flag = 1'b1; cyc();
    bus_if.dma_error_flag = 1'b0;
    chk("er_irq", 16'(bus_if.irq), 16'h1);
    chk("er_rqst", 16'(bus_if.dma_rqst), 16'h0);
    rd_chk("er_status", 4'h6, 16'h002C);
    cpu_wr(4'h6, 16'h0004);
    chk("er_irq_clr", 16'(bus_if.irq), 16'h0);
    rd_chk("er_clr_status", 4'h6, 16'h0028);

    // end and error together: error wins
    cpu_wr(4'h4, 16'h0007);
    bus_if.dma_error_flag = 1'b1;
    bus_if.dma_end_flag = 1'b1; cyc();
    bus_if.dma_error_flag = 1'b0;
    bus_if.dma_end_flag = 1'b0;
    rd_chk("ee_status", 4'h6, 16'h002C);
    chk("ee_irq", 16'(bus_if.irq), 16'h1);
    cpu_wr(4'h4, 16'h0002);
    chk("ee_irq_en_off", 16'(bus_if.irq), 16'h0);
    cpu_wr(4'h6, 16'h0004);

    // START with zero words
    cpu_wr(4'h2, 16'h0000);
    cpu_wr(4'h4, 16'h0001);
    chk("z_rqst", 16'(bus_if.dma_rqst), 16'h0);
    rd_chk("z_status", 4'h6, 16'h002A);
    chk("z_rqst_late", 16'(bus_if.dma_rqst), 16'h0);
    cpu_wr(4'h6, 16'h0002);

    // simultaneous push/pop at level 4, then flush against a push
    cpu_wr(4'h2, 16'h0008);
    cpu_wr(4'h4, 16'h0003);
    bus_if.dma_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_if.dev_in = 16'h00C0 + 16'(i);
      cyc();
    end
    bus_if.dma_ack = 1'b0;
    rd_chk("sp_level_pre", 4'hC, 16'h0004);
    bus_if.dma_ack = 1'b1;
    bus_if.dev_in = 16'h00C4;
    rd_chk("sp_pop", 4'h8, 16'h00C0);
    bus_if.dma_ack = 1'b0;
    rd_chk("sp_level", 4'hC, 16'h0004);
    bus_if.dma_ack = 1'b1;
    bus_if.dev_in = 16'h00C5;
    cpu_wr(4'h4, 16'h000A);
    bus_if.dma_ack = 1'b0;
    rd_chk("fp_level", 4'hC, 16'h0000);
    rd_chk("fp_count", 4'hE, 16'd6);

    // reset during RUN
    chk("rr_rqst_pre", 16'(bus_if.dma_rqst), 16'h1);
    reset = 1'b1;
    #2;
    chk("rr_rqst", 16'(bus_if.dma_rqst), 16'h0);
    chk("rr_ack", 16'(bus_if.dev_ack), 16'h0);
    chk("rr_irq", 16'(bus_if.irq), 16'h0);
    chk("rr_dev_out", bus_if.dev_out, 16'h0);
    chk("rr_addr", bus_if.dma_start_address, 16'h0);
    cyc();
    reset = 1'b0;
    cyc();
    rd_chk("rr_status", 4'h6, 16'h0028);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
